// File: rtl/regread_arbiter.sv
// Round-robin arbiter sharing one 32x32 register-file read port among NREQ requesters.
// Optional feature: define REGREAD_ARB_ZERO_BYPASS_EN to hardwire reads of register 0 to zero.
module regread_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [5*NREQ-1:0] addr,
    output logic [NREQ-1:0]   gnt,
    output logic [4:0]        sel,
    input  logic [31:0]       mux_data,
    output logic [31:0]       rdata,
    output logic [NREQ-1:0]   rvalid
);
    localparam int PTRW = $clog2(NREQ);

    logic [NREQ-1:0] r_gnt;
    logic [4:0]      r_sel;
    logic [PTRW-1:0] r_ptr;
    logic [31:0]     r_rdata;
    logic [NREQ-1:0] r_rvalid;

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic            w_grant;
    logic [PTRW-1:0] w_win;
    logic [NREQ-1:0] w_gntNext;
    logic [4:0]      w_winAddr;
    logic [31:0]     w_capData;

    // (base + k) mod NREQ; both operands are below NREQ so one subtraction suffices.
    function automatic logic [PTRW-1:0] wrapIdx(input logic [PTRW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return s[PTRW-1:0];
    endfunction

    always_comb begin
        w_elig  = req & ~r_gnt;
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_elig[wrapIdx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrapIdx(r_ptr, k);
            end
        end
        w_grant   = enable && w_found;
        w_gntNext = '0;
        if (w_grant) begin
            w_gntNext[w_win] = 1'b1;
        end
        w_winAddr = addr[5*w_win +: 5];
    end

    // r_sel still holds the granted address at the capture edge.
`ifdef REGREAD_ARB_ZERO_BYPASS_EN
    assign w_capData = (r_sel == 5'd0) ? 32'h0 : mux_data;
`else
    assign w_capData = mux_data;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gnt    <= '0;
            r_sel    <= '0;
            r_ptr    <= '0;
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_gnt    <= w_gntNext;
            r_rvalid <= r_gnt;
            if (w_grant) begin
                r_sel <= w_winAddr;
                r_ptr <= wrapIdx(w_win, 1);
            end
            if (|r_gnt) begin
                r_rdata <= w_capData;
            end
        end
    end

    assign gnt    = r_gnt;
    assign sel    = r_sel;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_regread_arbiter.sv
// Table-driven bench for regread_arbiter (NREQ=4) with hand-written reset-in-flight sequence.
module tb_regread_arbiter;
    logic        clock;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [19:0] addr;
    logic [3:0]  gnt;
    logic [4:0]  sel;
    logic [31:0] mux_data;
    logic [31:0] rdata;
    logic [3:0]  rvalid;

    int total = 0;
    int bad   = 0;

`ifdef REGREAD_ARB_ZERO_BYPASS_EN
    localparam logic [31:0] ZERO_READ_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] ZERO_READ_EXP = 32'hFFFF_FFFF;
`endif

    typedef struct {
        logic [3:0]  req;
        logic [19:0] addr;
        logic        en;
        logic [31:0] mux;
        logic [3:0]  expGnt;
        logic [4:0]  expSel;
        logic [3:0]  expRv;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[$];

    regread_arbiter #(.NREQ(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .sel      (sel),
        .mux_data (mux_data),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [19:0] packAddr(input logic [4:0] a0, input logic [4:0] a1,
                                             input logic [4:0] a2, input logic [4:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic addVec(input logic [3:0] r, input logic [19:0] a, input logic e,
                          input logic [31:0] m, input logic [3:0] g, input logic [4:0] s,
                          input logic [3:0] rv, input logic [31:0] rd);
        vec_t v;
        v.req = r; v.addr = a; v.en = e; v.mux = m;
        v.expGnt = g; v.expSel = s; v.expRv = rv; v.expRdata = rd;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req      = v.req;
        addr     = v.addr;
        enable   = v.en;
        mux_data = v.mux;
    endtask

    task automatic stepEdge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [19:0] dflt;
        logic [19:0] zeroA1;
        dflt   = packAddr(5'd10, 5'd11, 5'd13, 5'd14);
        zeroA1 = packAddr(5'd10, 5'd0, 5'd13, 5'd14);

        // single read to requester 2
        addVec(4'b0100, dflt, 1'b1, 32'h0000_0001, 4'b0100, 5'd13, 4'b0000, 32'h0);
        addVec(4'b0000, dflt, 1'b1, 32'h1234_5678, 4'b0000, 5'd13, 4'b0100, 32'h1234_5678);
        addVec(4'b0000, dflt, 1'b1, 32'h0000_0002, 4'b0000, 5'd13, 4'b0000, 32'h1234_5678);
        // move ptr to 0, then full contention with wrap
        addVec(4'b1000, dflt, 1'b1, 32'h0000_0003, 4'b1000, 5'd14, 4'b0000, 32'h1234_5678);
        addVec(4'b1111, dflt, 1'b1, 32'hA000_0003, 4'b0001, 5'd10, 4'b1000, 32'hA000_0003);
        addVec(4'b1111, dflt, 1'b1, 32'hA000_0000, 4'b0010, 5'd11, 4'b0001, 32'hA000_0000);
        addVec(4'b1111, dflt, 1'b1, 32'hA000_0001, 4'b0100, 5'd13, 4'b0010, 32'hA000_0001);
        addVec(4'b1111, dflt, 1'b1, 32'hA000_0002, 4'b1000, 5'd14, 4'b0100, 32'hA000_0002);
        addVec(4'b1111, dflt, 1'b1, 32'hA000_0013, 4'b0001, 5'd10, 4'b1000, 32'hA000_0013);
        addVec(4'b0000, dflt, 1'b1, 32'hB000_0000, 4'b0000, 5'd10, 4'b0001, 32'hB000_0000);
        addVec(4'b0000, dflt, 1'b1, 32'h0000_0005, 4'b0000, 5'd10, 4'b0000, 32'hB000_0000);
        // single requester held: every other cycle
        addVec(4'b0001, dflt, 1'b1, 32'h0000_0006, 4'b0001, 5'd10, 4'b0000, 32'hB000_0000);
        addVec(4'b0001, dflt, 1'b1, 32'hC000_0001, 4'b0000, 5'd10, 4'b0001, 32'hC000_0001);
        addVec(4'b0001, dflt, 1'b1, 32'h0000_0007, 4'b0001, 5'd10, 4'b0000, 32'hC000_0001);
        addVec(4'b0001, dflt, 1'b1, 32'hC000_0002, 4'b0000, 5'd10, 4'b0001, 32'hC000_0002);
        addVec(4'b0001, dflt, 1'b1, 32'h0000_0008, 4'b0001, 5'd10, 4'b0000, 32'hC000_0002);
        addVec(4'b0001, dflt, 1'b1, 32'hC000_0003, 4'b0000, 5'd10, 4'b0001, 32'hC000_0003);
        addVec(4'b0000, dflt, 1'b1, 32'h0000_0009, 4'b0000, 5'd10, 4'b0000, 32'hC000_0003);
        // ptr back to 0, then enable gating
        addVec(4'b1000, dflt, 1'b1, 32'h0000_000A, 4'b1000, 5'd14, 4'b0000, 32'hC000_0003);
        addVec(4'b0000, dflt, 1'b1, 32'hD000_0003, 4'b0000, 5'd14, 4'b1000, 32'hD000_0003);
        addVec(4'b0011, dflt, 1'b1, 32'h0000_000B, 4'b0001, 5'd10, 4'b0000, 32'hD000_0003);
        addVec(4'b0011, dflt, 1'b0, 32'hE000_0000, 4'b0000, 5'd10, 4'b0001, 32'hE000_0000);
        addVec(4'b0011, dflt, 1'b0, 32'h0000_000C, 4'b0000, 5'd10, 4'b0000, 32'hE000_0000);
        addVec(4'b0011, dflt, 1'b0, 32'h0000_000D, 4'b0000, 5'd10, 4'b0000, 32'hE000_0000);
        addVec(4'b0011, dflt, 1'b1, 32'h0000_000E, 4'b0010, 5'd11, 4'b0000, 32'hE000_0000);
        addVec(4'b0000, dflt, 1'b1, 32'hE000_0001, 4'b0000, 5'd11, 4'b0010, 32'hE000_0001);
        // read of register 0
        addVec(4'b0010, zeroA1, 1'b1, 32'h0000_000F, 4'b0010, 5'd0, 4'b0000, 32'hE000_0001);
        addVec(4'b0000, zeroA1, 1'b1, 32'hFFFF_FFFF, 4'b0000, 5'd0, 4'b0010, ZERO_READ_EXP);
        addVec(4'b0000, zeroA1, 1'b1, 32'h0000_0010, 4'b0000, 5'd0, 4'b0000, ZERO_READ_EXP);

        reset    = 1'b0;
        enable   = 1'b0;
        req      = '0;
        addr     = '0;
        mux_data = 32'h5555_AAAA;
        #12;
        checkOutput("reset gnt",    32'(gnt),    32'h0);
        checkOutput("reset sel",    32'(sel),    32'h0);
        checkOutput("reset rvalid", 32'(rvalid), 32'h0);
        checkOutput("reset rdata",  rdata,       32'h0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            stepEdge();
            checkOutput($sformatf("row%0d gnt", i),    32'(gnt),    32'(vecs[i].expGnt));
            checkOutput($sformatf("row%0d sel", i),    32'(sel),    32'(vecs[i].expSel));
            checkOutput($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(vecs[i].expRv));
            checkOutput($sformatf("row%0d rdata", i),  rdata,       vecs[i].expRdata);
        end

        // reset while a read is in flight
        req      = 4'b0001;
        addr     = packAddr(5'd7, 5'd11, 5'd13, 5'd14);
        enable   = 1'b1;
        mux_data = 32'hDEAD_BEEF;
        stepEdge();
        checkOutput("midrst pre gnt", 32'(gnt), 32'h1);
        checkOutput("midrst pre sel", 32'(sel), 32'd7);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst async gnt",    32'(gnt),    32'h0);
        checkOutput("midrst async sel",    32'(sel),    32'h0);
        checkOutput("midrst async rvalid", 32'(rvalid), 32'h0);
        checkOutput("midrst async rdata",  rdata,       32'h0);
        stepEdge();
        checkOutput("midrst held rvalid", 32'(rvalid), 32'h0);
        checkOutput("midrst held rdata",  rdata,       32'h0);
        #2;
        req   = 4'b0011;
        reset = 1'b1;
        stepEdge();
        checkOutput("midrst post gnt", 32'(gnt), 32'h1);
        checkOutput("midrst post sel", 32'(sel), 32'd7);
        stepEdge();
        checkOutput("midrst post rvalid", 32'(rvalid), 32'h1);
        checkOutput("midrst post rdata",  rdata,       32'hDEAD_BEEF);
        checkOutput("midrst next gnt",    32'(gnt),    32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regread_arbiter.md
# regread_arbiter

- Shares the single 32-entry, 32-bit register-file read port among `NREQ` requesters, for example the game-logic FSM, the display renderer and the debug scanner.
- Requesters are served in round-robin order.
- Drives the 5-bit select into the 32:1 read mux and registers the mux output.
- Returns the captured data to the winning requester with a per-requester valid strobe; a new read can be issued every cycle.

## Interface

- `NREQ`, default 4: number of requesters, legal range 2..8.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: when low, no new grants are issued; reads already in flight still complete.
- `req`  in  NREQ: bit i high means requester i wants a read.
- `addr`  in  5*NREQ: register index of requester i, in bits [5i+4:5i]; must be held stable while `req[i]` is high.
- `gnt`  out  NREQ: one-hot, one-cycle acknowledge; requester i's address has been launched.
- `sel`  out  5: select into the 32:1 read mux.
- `mux_data`  in  32: combinational output of the read mux.
- `rdata`  out  32: captured read data, shared by all requesters.
- `rvalid`  out  NREQ: one-hot, one-cycle; `rdata` belongs to requester i.

## Operation

**Stage A (arbitrate), every cycle:**
- Eligible requesters: `req & ~gnt`. The currently granted requester is masked, so a held request cannot win twice on consecutive edges.
- If `enable` is high and any requester is eligible, the winner is the first eligible index at or after pointer `ptr`, searching upward with wrap.
- At the edge: `gnt` ← onehot(winner), `sel` ← addr of winner, `ptr` ← (winner+1) mod NREQ.
- If there is no winner: `gnt` ← 0, `sel` holds its previous value, `ptr` is unchanged.

**Stage B (capture):**
- On the edge after `gnt[i]` was high: `rdata` ← `mux_data`, `rvalid` ← previous `gnt`.
- If no grant was outstanding: `rvalid` ← 0 and `rdata` holds.

**Requester protocol:**
- Raise `req[i]` with `addr[i]`.
- On seeing `gnt[i]`, either drop `req[i]` or present the next address before the next edge.
- `rdata` is valid only while `rvalid[i]` is high.

**Boundary cases:**
- All requesters asserting: grants rotate i, i+1, … with no requester starved; maximum wait is NREQ−1 grants.
- Single requester held high: granted every other cycle, because of the `gnt` mask.
- `enable` dropping while a grant is in flight: the matching `rvalid` still fires the next cycle.
- `ptr` is a counter of width ceil(log2 NREQ) and wraps from NREQ−1 to 0.

**Reset (asynchronous, any time):**
- `gnt`, `rvalid`, `sel`, `rdata` all cleared to 0; `ptr` cleared to 0.
- A read in flight at reset is discarded; no `rvalid` is issued for it.

## Timing

- Request sampled high at edge E0 → `gnt[i]` and `sel` valid from E0 until E1.
- Edge E1 → `rvalid[i]` and `rdata` valid from E1 until E2.
- Grant latency is 1 edge; data latency is 2 edges from the first sampled request.
- Throughput is one read per cycle across different requesters.
- `mux_data` must settle within one cycle of `sel` changing; this is a combinational path only, with no extra register.
- Outputs are glitch-free registers; the only combinational path is inside the arbiter and feeds registers only.

## Configuration

- `REGREAD_ARB_ZERO_BYPASS_EN` defined:
  - A grant whose address is 0 captures `rdata` = 32'h0 regardless of `mux_data`; `r0` is hardwired zero.
  - Timing and `rvalid` are unchanged.
- Not defined: `rdata` always equals `mux_data` captured at E1.

## Test plan

- **Reset mid-flight:** `req`=4'b0001, `addr0`=7, `mux_data`=32'hDEAD_BEEF; assert `reset` low after `gnt[0]`, before E1 → `rvalid`=0, `rdata`=0, `gnt`=0, `sel`=0; after release, the next grant goes to requester 0.
- **Single read:** `req`=4'b0100, `addr2`=13, `mux_data`=32'h1234_5678 → `gnt`=4'b0100 and `sel`=13 one edge later; `rvalid`=4'b0100 and `rdata`=32'h1234_5678 the following edge.
- **Full contention:** `req`=4'b1111 held, `ptr`=0 → `gnt` sequence 0001, 0010, 0100, 1000, 0001 on the grant cycles; every requester is served within 4 grants.
- **Held single request:** `req`=4'b0001 held for 6 cycles → `gnt[0]` pattern 1,0,1,0,1,0; `rvalid[0]` follows one cycle later.
- **Enable gating:** `req`=4'b0011 with `enable` dropped on the edge that issues `gnt`=4'b0001 → the matching `rvalid`=4'b0001 still fires; no further `gnt` until `enable`=1; then `gnt`=4'b0010.
- **Zero bypass:** `addr1`=0, `mux_data`=32'hFFFF_FFFF → `rdata`=0 with the macro defined, 32'hFFFF_FFFF without it.
